// File: rtl/rtcomp_vc.sv
// Per-VC routing computation for one mesh router input port: computes a route on
// head flits and pins it per virtual channel until the packet's tail passes.
module rtcomp_vc #(
    parameter int MY_XPOS    = 0,
    parameter int MY_YPOS    = 0,
    parameter int XN         = 4,
    parameter int YN         = 4,
    parameter int VCN        = 2,
    parameter int ROUTE_MODE = 0,
    parameter int DATAW      = 31,
    parameter int DST_LSB    = 0,
    parameter int DST_MSB    = 7,
    parameter int VCH_LSB    = 8,
    parameter int VCH_MSB    = 9,
    parameter int PORTW      = 2,
    parameter int VCHW       = VCH_MSB - VCH_LSB
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW:0]   bdata,
    input  logic             en,
    input  logic             head,
    input  logic             tail,
    input  logic [3:0]       cong,
    output logic [PORTW:0]   port,
    output logic [VCHW:0]    ovch,
    output logic             route_vld,
    output logic             err,
    output logic [VCN-1:0]   busy
);
    localparam int HW  = (DST_MSB - DST_LSB + 1) / 2;
    localparam int HW1 = HW + 1;
    localparam int VW  = VCHW + 1;
    localparam int PW  = PORTW + 1;

    localparam logic [PW-1:0]  P_E     = PW'(0);
    localparam logic [PW-1:0]  P_W     = PW'(1);
    localparam logic [PW-1:0]  P_S     = PW'(2);
    localparam logic [PW-1:0]  P_N     = PW'(3);
    localparam logic [PW-1:0]  P_LOCAL = PW'(4);
    localparam logic [HW-1:0]  MY_X    = HW'(MY_XPOS);
    localparam logic [HW-1:0]  MY_Y    = HW'(MY_YPOS);
    localparam logic [HW1-1:0] XN_W    = HW1'(XN);
    localparam logic [HW1-1:0] YN_W    = HW1'(YN);

    typedef enum logic {ST_IDLE, ST_ACTIVE} vc_state_e;

    vc_state_e         state_q    [VCN];
    vc_state_e         state_d    [VCN];
    logic [PW-1:0]     ent_port_q [VCN];
    logic [PW-1:0]     ent_port_d [VCN];
    logic [VW-1:0]     ent_ovch_q [VCN];
    logic [VW-1:0]     ent_ovch_d [VCN];
    logic [PW-1:0]     port_hold_q, port_hold_d;
    logic [VW-1:0]     ovch_hold_q, ovch_hold_d;

    logic [HW-1:0]     dst_x, dst_y;
    logic [VW-1:0]     vch;
    logic [VCN-1:0]    vc_sel;
    logic              vc_ok, dst_ok;
    logic              cur_active;
    logic [PW-1:0]     cur_port;
    logic [VW-1:0]     cur_ovch;
    logic [PW-1:0]     route_port;
    logic              x_gt, x_lt, y_gt, y_lt;
    logic              x_cong, y_cong;
    logic [PW-1:0]     x_port, y_port;

    assign dst_x  = bdata[DST_LSB +: HW];
    assign dst_y  = bdata[DST_LSB + HW +: HW];
    assign vch    = bdata[VCH_MSB:VCH_LSB];
    assign vc_ok  = |vc_sel;
    assign dst_ok = ({1'b0, dst_x} < XN_W) && ({1'b0, dst_y} < YN_W);

    genvar gi;
    generate
        for (gi = 0; gi < VCN; gi++) begin : g_vc
            assign vc_sel[gi] = (vch == VW'(gi));
            assign busy[gi]   = (state_q[gi] == ST_ACTIVE);
        end
    endgenerate

    always_comb begin
        cur_active = 1'b0;
        cur_port   = '0;
        cur_ovch   = '0;
        for (int v = 0; v < VCN; v++) begin
            if (vc_sel[v]) begin
                cur_active = (state_q[v] == ST_ACTIVE);
                cur_port   = ent_port_q[v];
                cur_ovch   = ent_ovch_q[v];
            end
        end
    end

    // Minimal routing; unsigned compares, no torus wrap.
    always_comb begin
        x_gt   = dst_x > MY_X;
        x_lt   = dst_x < MY_X;
        y_gt   = dst_y > MY_Y;
        y_lt   = dst_y < MY_Y;
        x_port = x_gt ? P_E : P_W;
        y_port = y_gt ? P_S : P_N;
        x_cong = cong[0];
        y_cong = y_gt ? cong[2] : cong[3];
        route_port = P_LOCAL;
        if (ROUTE_MODE == 1) begin
            if (y_gt || y_lt)
                route_port = y_port;
            else if (x_gt || x_lt)
                route_port = x_port;
        end else if (ROUTE_MODE == 2) begin
            if (x_lt)
                route_port = P_W;
            else if (x_gt && (y_gt || y_lt))
                route_port = (x_cong && !y_cong) ? y_port : P_E;
            else if (x_gt)
                route_port = P_E;
            else if (y_gt || y_lt)
                route_port = y_port;
        end else begin
            if (x_gt || x_lt)
                route_port = x_port;
            else if (y_gt || y_lt)
                route_port = y_port;
        end
    end

    always_comb begin
        state_d     = state_q;
        ent_port_d  = ent_port_q;
        ent_ovch_d  = ent_ovch_q;
        port_hold_d = port_hold_q;
        ovch_hold_d = ovch_hold_q;
        port        = port_hold_q;
        ovch        = ovch_hold_q;
        route_vld   = 1'b0;
        err         = 1'b0;
        if (en) begin
            if (!vc_ok) begin
                err = 1'b1;
            end else if (head) begin
                if (!dst_ok) begin
                    err = 1'b1;
                end else begin
                    // A head on an active VC is flagged but still replaces the route.
                    err       = cur_active;
                    route_vld = 1'b1;
                    port      = route_port;
                    ovch      = vch;
                    for (int v = 0; v < VCN; v++) begin
                        if (vc_sel[v]) begin
                            ent_port_d[v] = route_port;
                            ent_ovch_d[v] = vch;
                            state_d[v]    = tail ? ST_IDLE : ST_ACTIVE;
                        end
                    end
                end
            end else if (cur_active) begin
                route_vld = 1'b1;
                port      = cur_port;
                ovch      = cur_ovch;
                for (int v = 0; v < VCN; v++) begin
                    if (vc_sel[v] && tail)
                        state_d[v] = ST_IDLE;
                end
            end else begin
                err = 1'b1;
            end
            if (route_vld) begin
                port_hold_d = port;
                ovch_hold_d = ovch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int v = 0; v < VCN; v++) begin
                state_q[v]    <= ST_IDLE;
                ent_port_q[v] <= '0;
                ent_ovch_q[v] <= '0;
            end
            port_hold_q <= '0;
            ovch_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            ent_port_q  <= ent_port_d;
            ent_ovch_q  <= ent_ovch_d;
            port_hold_q <= port_hold_d;
            ovch_hold_q <= ovch_hold_d;
        end
    end
endmodule

// File: tb/tb_rtcomp_vc.sv
// Scoreboard bench: three routers at (1,1) in a 4x4 mesh, one per routing mode,
// driven with the same flits and checked against a per-mode packet-level model.
module tb_rtcomp_vc;
    logic        clk = 1'b0;
    logic        rst_, en, head, tail;
    logic [31:0] bdata;
    logic [3:0]  cong;
    logic [2:0]  port_w  [3];
    logic [1:0]  ovch_w  [3];
    logic        vld_w   [3];
    logic        err_w   [3];
    logic [1:0]  busy_w  [3];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            rtcomp_vc #(
                .MY_XPOS(1), .MY_YPOS(1), .XN(4), .YN(4), .VCN(2), .ROUTE_MODE(gi),
                .DATAW(31), .DST_LSB(0), .DST_MSB(7), .VCH_LSB(8), .VCH_MSB(9), .PORTW(2)
            ) u_dut (
                .clk(clk), .rst_(rst_), .bdata(bdata), .en(en), .head(head), .tail(tail),
                .cong(cong), .port(port_w[gi]), .ovch(ovch_w[gi]), .route_vld(vld_w[gi]),
                .err(err_w[gi]), .busy(busy_w[gi])
            );
        end
    endgenerate

    typedef struct packed {
        logic            chk;
        logic            en;
        logic [2:0][2:0] port;
        logic [2:0][1:0] ovch;
        logic [2:0]      vld;
        logic [2:0]      err;
        logic [2:0][1:0] busy;
        logic [15:0]     id;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mx;
    int         checks = 0;
    int         errors = 0;
    int         txn    = 0;

    // Packet-level reference state per mode and per VC.
    bit         act   [3][2];
    logic [2:0] sport [3][2];
    logic [2:0] hport [3];
    logic [1:0] hovch [3];

    // Output port: 0=E 1=W 2=S 3=N 4=Local.
    function automatic int route(int mode, int dx, int dy, logic [3:0] cg);
        int  xp;
        int  yp;
        bit  yc;
        xp = (dx > 0) ? 0 : 1;
        yp = (dy > 0) ? 2 : 3;
        if (dx == 0 && dy == 0) return 4;
        if (mode == 0) return (dx != 0) ? xp : yp;
        if (mode == 1) return (dy != 0) ? yp : xp;
        if (dx < 0) return 1;
        if (dx == 0) return yp;
        if (dy == 0) return 0;
        yc = (dy > 0) ? cg[2] : cg[3];
        if (cg[0] && !yc) return yp;
        return 0;
    endfunction

    task automatic check(string nm, int id, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s txn=%0d actual=%0h required=%0h", nm, id, a, e);
        end
    endtask

    task automatic send(bit r, bit e, bit h, bit t, int vc, int x, int y,
                        logic [3:0] cg, bit chk = 1'b1);
        exp_t       ex;
        logic [2:0] p;
        logic [1:0] o;
        bit         v;
        bit         er;
        @(posedge clk);
        #1;
        rst_ = r; en = e; head = h; tail = t; cong = cg;
        bdata        = '0;
        bdata[3:0]   = x[3:0];
        bdata[7:4]   = y[3:0];
        bdata[9:8]   = vc[1:0];
        bdata[31:10] = 22'($urandom());
        ex     = '0;
        ex.chk = chk;
        ex.en  = e;
        ex.id  = 16'(txn);
        for (int m = 0; m < 3; m++) begin
            p  = hport[m];
            o  = hovch[m];
            v  = 1'b0;
            er = 1'b0;
            ex.busy[m] = {act[m][1], act[m][0]};
            if (e) begin
                if (vc >= 2) begin
                    er = 1'b1;
                end else if (h) begin
                    if (x >= 4 || y >= 4) begin
                        er = 1'b1;
                    end else begin
                        p  = 3'(route(m, x - 1, y - 1, cg));
                        o  = vc[1:0];
                        v  = 1'b1;
                        er = act[m][vc];
                        if (!r) begin
                            act[m][vc]   = !t;
                            sport[m][vc] = p;
                        end
                    end
                end else if (act[m][vc]) begin
                    p = sport[m][vc];
                    o = vc[1:0];
                    v = 1'b1;
                    if (!r && t) act[m][vc] = 1'b0;
                end else begin
                    er = 1'b1;
                end
                if (v && !r) begin
                    hport[m] = p;
                    hovch[m] = o;
                end
            end
            if (r) begin
                act[m][0] = 1'b0;
                act[m][1] = 1'b0;
                hport[m]  = '0;
                hovch[m]  = '0;
            end
            ex.port[m] = p;
            ex.ovch[m] = o;
            ex.vld[m]  = v;
            ex.err[m]  = er;
        end
        $display("txn %0d rst=%0d en=%0d h=%0d t=%0d vc=%0d dst=(%0d,%0d) cong=%b exp port=%0d/%0d/%0d vld=%b err=%b",
                 txn, r, e, h, t, vc, x, y, cg, ex.port[0], ex.port[1], ex.port[2], ex.vld, ex.err);
        sb_q.push_back(ex);
        txn++;
    endtask

    task automatic idle();
        send(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 4'b0000);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mx = sb_q.pop_front();
            if (mx.chk) begin
                for (int m = 0; m < 3; m++) begin
                    check($sformatf("busy_m%0d", m), int'(mx.id), 32'(busy_w[m]), 32'(mx.busy[m]));
                    check($sformatf("route_vld_m%0d", m), int'(mx.id), 32'(vld_w[m]), 32'(mx.vld[m]));
                    check($sformatf("err_m%0d", m), int'(mx.id), 32'(err_w[m]), 32'(mx.err[m]));
                    if (mx.vld[m] || !mx.en) begin
                        check($sformatf("port_m%0d", m), int'(mx.id), 32'(port_w[m]), 32'(mx.port[m]));
                        check($sformatf("ovch_m%0d", m), int'(mx.id), 32'(ovch_w[m]), 32'(mx.ovch[m]));
                    end
                end
            end
        end
    end

    initial begin
        int vc;
        rst_ = 1'b1; en = 1'b0; head = 1'b0; tail = 1'b0; cong = '0; bdata = '0;
        send(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 4'b0000, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 4'b0000);
        idle();
        // XY single packet east
        send(0, 1, 1, 0, 0, 3, 0, 4'b0000);
        send(0, 1, 0, 0, 0, 0, 0, 4'b0000);
        send(0, 1, 0, 0, 0, 0, 0, 4'b0000);
        send(0, 1, 0, 1, 0, 0, 0, 4'b0000);
        idle();
        // Interleaved VCs
        send(0, 1, 1, 0, 0, 1, 3, 4'b0000);
        send(0, 1, 1, 0, 1, 0, 1, 4'b0000);
        send(0, 1, 0, 0, 0, 0, 0, 4'b0000);
        send(0, 1, 0, 0, 1, 0, 0, 4'b0000);
        send(0, 1, 0, 0, 0, 0, 0, 4'b0000);
        send(0, 1, 0, 0, 1, 0, 0, 4'b0000);
        send(0, 1, 0, 1, 1, 0, 0, 4'b0000);
        idle();
        send(0, 1, 0, 1, 0, 0, 0, 4'b0000);
        // Mode comparison and west-first congestion choices
        send(0, 1, 1, 1, 0, 3, 3, 4'b0001);
        send(0, 1, 1, 1, 0, 3, 3, 4'b0100);
        send(0, 1, 1, 1, 0, 0, 3, 4'b0010);
        send(0, 1, 1, 0, 1, 3, 3, 4'b0001);
        send(0, 1, 0, 0, 1, 0, 0, 4'b0100);
        send(0, 1, 0, 1, 1, 0, 0, 4'b1111);
        idle();
        // Errors
        send(0, 1, 0, 0, 1, 0, 0, 4'b0000);
        send(0, 1, 1, 0, 0, 4, 0, 4'b0000);
        send(0, 1, 1, 0, 0, 3, 0, 4'b0000);
        send(0, 1, 1, 0, 0, 1, 3, 4'b0000);
        send(0, 1, 0, 0, 0, 0, 0, 4'b0000);
        send(0, 1, 0, 0, 2, 0, 0, 4'b0000);
        send(0, 1, 0, 1, 0, 0, 0, 4'b0000);
        // Single-flit local packet, then reset mid-packet
        send(0, 1, 1, 1, 0, 1, 1, 4'b0000);
        idle();
        send(0, 1, 1, 0, 0, 3, 0, 4'b0000);
        send(1, 0, 0, 0, 0, 0, 0, 4'b0000);
        idle();
        send(0, 1, 0, 0, 0, 0, 0, 4'b0000);
        idle();
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            vc = ($urandom_range(0, 9) == 0) ? 2 + int'($urandom_range(0, 1))
                                             : int'($urandom_range(0, 1));
            send($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, vc,
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 4'($urandom()));
        end
        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rtcomp_vc.md
# rtcomp_vc

Parametrised, per-virtual-channel routing computation unit for one router input port of a 2-D mesh. On a head flit it computes the output port from the destination field using a selectable routing algorithm (XY, YX, or west-first minimal adaptive). It then pins that route, together with the output VC, in a per-VC route table until the tail flit passes. It sits between the input buffer and the switch/VC allocator, and replaces single-route latching with wormhole-correct route holding across interleaved VCs.

## Interface

- `MY_XPOS`, default 0: router X coordinate.
- `MY_YPOS`, default 0: router Y coordinate.
- `XN`, default 4: mesh columns; a valid destination X is `0..XN-1`.
- `YN`, default 4: mesh rows; a valid destination Y is `0..YN-1`.
- `VCN`, default 2: virtual channels per port (≥1); the route table has `VCN` entries.
- `ROUTE_MODE`, default 0: routing algorithm; 0 = XY, 1 = YX, 2 = west-first adaptive.
- `clk`  in  1: sole clock; everything is on its rising edge.
- `rst_`  in  1: reset, synchronous and active-high. The name follows the codebase; the polarity is fixed high.
- `bdata`  in  `DATAW+1`: flit. The destination is in `DST_MSB:DST_LSB` (X in the low half, Y in the high half). The input VC is in `VCH_MSB:VCH_LSB`.
- `en`  in  1: flit valid this cycle.
- `head`  in  1: flit is a head flit (qualified by `en`).
- `tail`  in  1: flit is a tail flit. `head & tail` together mean a single-flit packet.
- `cong`  in  4: congestion per output, bit order {N,S,W,E}; 1 = congested. Used only when `ROUTE_MODE=2`.
- `port`  out  `PORTW+1`: output port. 0 = E, 1 = W, 2 = S, 3 = N, 4 = Local.
- `ovch`  out  `VCHW+1`: output VC.
- `route_vld`  out  1: `port`/`ovch` are valid for the current flit.
- `err`  out  1: protocol or address error on the current flit.
- `busy`  out  `VCN`: bit v = 1 while VC v holds a route.

## Operation

- Per-VC state machine with two states:
  - IDLE → ACTIVE on a non-error head with `tail=0`.
  - ACTIVE → IDLE on any accepted flit with `tail=1`.
  - A head with `tail=1` leaves the entry IDLE.
- `busy[v]` = 1 exactly when entry v is ACTIVE.
- Entry v holds the routed port (3 b) and the output VC.
- The input VC index v is taken from the `VCH` field. If v ≥ `VCN`, the flit is flagged `err=1`, `route_vld=0`, and no state changes.
- Route function (head only). With dx = dstX − `MY_XPOS` and dy = dstY − `MY_YPOS`, both signed:
  - dx = dy = 0 → Local.
  - A positive Y difference (dy > 0) → South; negative → North.
  - Mode 0 (XY): dx > 0 → E, dx < 0 → W, otherwise Y.
  - Mode 1 (YX): Y first, then X.
  - Mode 2 (west-first):
    - dx < 0 → W, unconditionally.
    - If exactly one productive direction exists among E/S/N, use it.
    - If two exist, pick the uncongested one.
    - If both or neither are congested, pick the X direction.
- Output VC is always equal to the input VC.
- Head in IDLE:
  - `port`/`ovch` are the computed values, combinationally in the same cycle.
  - `route_vld=1`.
  - The entry is written on the clock edge.
- Head in ACTIVE: protocol error.
  - `err=1`.
  - The route is recomputed, output with `route_vld=1`, and overwrites the entry (new packet wins).
- Body/tail in ACTIVE: `port`/`ovch` come from the entry, `route_vld=1`.
- Body/tail in IDLE: `err=1`, `route_vld=0`, no state change.
- Destination out of range (dstX ≥ `XN` or dstY ≥ `YN`) on a head: `err=1`, `route_vld=0`, entry unchanged.
- When `en=0`:
  - `port`/`ovch` hold the last value driven with `route_vld=1`, kept in a separate hold register.
  - `route_vld=0`, `err=0`.
- Arithmetic: coordinate compares are unsigned on `DST` sub-field widths. There is no wrap-around; the mesh is not a torus.

## Timing

- Route latency is 0 cycles: combinational from `bdata`/`en`/`head`/`cong` to `port`/`ovch`/`route_vld`/`err`.
- Table update, hold register update and `busy` change take effect on the rising edge after the flit.
- One flit per cycle. Back-to-back flits on different VCs are independent.
- A head and a tail on the same VC in consecutive cycles are legal.
- Reset, on the first edge with `rst_=1`:
  - All entries go IDLE, with stored port = 0 and ovch = 0.
  - Hold registers = 0.
  - `busy` = 0.
  - While `en=0`: `port` = 0, `ovch` = 0, `route_vld` = 0, `err` = 0.
  - Reset mid-packet discards all routes; the following body flit reports `err=1`.
- `cong` is sampled only in the head cycle. Later congestion changes never alter a held route.

## Test plan

- XY routing at MY=(1,1), mesh 4×4, mode 0:
  - Head, dst (3,0), VC0 → `port=0` (E), `route_vld=1`, same cycle; `busy=01` next cycle.
  - Two bodies → `port=0`.
  - Tail → `port=0`, then `busy=00`.
- Interleaved VCs, mode 0:
  - VC0 head dst (1,3) → S.
  - VC1 head dst (0,1) → W.
  - Alternate VC0/VC1 bodies → 2/1/2/1.
  - VC1 tail → `busy=01`.
- YX vs XY, dst (3,3) from (1,1): mode 1 → S (2); mode 0 → E (0).
- West-first, mode 2, from (1,1):
  - dst (3,3), `cong=0001` → S.
  - `cong=0100` → E.
  - dst (0,3), `cong=0010` → W.
  - Change `cong` mid-packet → route unchanged.
- Errors:
  - Body on IDLE VC1 → `err=1`, `route_vld=0`.
  - Head dst (4,0) in 4×4 → `err=1`, `busy` unchanged.
  - Head on ACTIVE VC0 → `err=1`, entry overwritten with the new route.
- Reset/single-flit:
  - Head+tail dst (1,1) → `port=4`, `busy` stays 0.
  - Assert `rst_` mid-packet → `busy=0`, `port=0`; the next body gives `err=1`.
